// File: rtl/aq_fifo_rd_unpack.sv
// aq_fifo_rd_unpack: FWFT FIFO read-side consumer that unpacks IN_WIDTH words into an OUT_WIDTH valid/ready stream
module aq_fifo_rd_unpack #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 RDCLK,
  input  logic                 RST,
  input  logic                 FIFO_RDRSTBUSY,
  input  logic                 FIFO_EMPTY,
  input  logic [IN_WIDTH-1:0]  FIFO_DOUT,
  output logic                 FIFO_RDEN,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic [OUT_WIDTH-1:0] M_DATA,
  output logic                 M_LAST,
  output logic [31:0]          WORD_CNT
);
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IW    = $clog2(RATIO) + 1;
  if (IN_WIDTH != OUT_WIDTH * RATIO ||
      !(RATIO == 1 || RATIO == 2 || RATIO == 4 || RATIO == 8)) begin : g_bad_ratio
    $fatal(1, "aq_fifo_rd_unpack: IN_WIDTH/OUT_WIDTH must be an exact power of two in 1..8");
  end
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_q, hold_d;
  logic [IW-1:0]         idx_q, idx_d, sel;
  logic [31:0]           cnt_q, cnt_d;
  logic                  last_slice, accept, lastacc;
  assign last_slice = idx_q == IW'(RATIO - 1);
  assign accept     = M_VALID & M_READY;
  assign lastacc    = accept & last_slice;
  assign WORD_CNT   = cnt_q;
  always_ff @(posedge RDCLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  // a pop on the last accepted slice overrides the return to IDLE, so back-to-back words have no bubble
  always_comb begin
    state_d = FIFO_RDEN ? ACTIVE : (lastacc ? IDLE : state_q);
    hold_d  = FIFO_RDEN ? FIFO_DOUT : hold_q;
    idx_d   = FIFO_RDEN ? '0 : (accept ? idx_q + IW'(1) : idx_q);
    cnt_d   = FIFO_RDEN ? cnt_q + 32'd1 : cnt_q;
  end
  always_comb begin
    M_VALID   = state_q == ACTIVE;
    M_LAST    = M_VALID & last_slice;
    FIFO_RDEN = !RST & !FIFO_RDRSTBUSY & !FIFO_EMPTY & (!M_VALID | lastacc);
    sel       = LSB_FIRST ? idx_q : IW'(RATIO - 1) - idx_q;
    M_DATA    = '0;
    for (int i = 0; i < RATIO; i++)
      if (sel == IW'(i)) M_DATA = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
  end
endmodule
